reg_load_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one n-bit loadable register (a `reg_odd` instance with sync clear) among REQ requesters. It serialises each write into a fixed three-cycle grant → load → acknowledge sequence and serves a priority clear request. It sits between several producer blocks and the shared register, and is the only driver of that register's `ld`, `clr` and `data_in`.

---
 rtl/reg_arb_pkg.sv | 19 +
 rtl/reg_load_arbiter_if.sv | 34 +++
 rtl/reg_odd.sv | 29 ++
 rtl/reg_load_arbiter.sv | 124 ++++++++++++
 tb/tb_reg_load_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_arb_pkg.sv
`default_nettype none
// ============================================================================
// reg_arb_pkg : state encoding shared by the reg_load_arbiter slice
// Revision    : 1.0
// ============================================================================
package reg_arb_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    LOAD  = 3'd2,
    ACK   = 3'd3,
    CLEAR = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_load_arbiter_if.sv
`default_nettype none
// ============================================================================
// reg_load_arbiter_if : requester/register bundle for reg_load_arbiter
// Revision            : 1.0
// ============================================================================
interface reg_load_arbiter_if #(
  parameter int n   = 8,
  parameter int REQ = 4
);

  localparam int OW = (REQ > 1) ? $clog2(REQ) : 1;

  logic [REQ-1:0]   req_valid;
  logic [REQ*n-1:0] req_data;
  logic [REQ-1:0]   req_ready;
  logic             clr_req;
  logic             clr_ack;
  logic [n-1:0]     reg_q;
  logic [OW-1:0]    owner;
  logic             busy;

  // Requester side drives requests; the arbiter answers.
  modport master (
    output req_valid, req_data, clr_req,
    input  req_ready, clr_ack, reg_q, owner, busy
  );

  modport slave (
    input  req_valid, req_data, clr_req,
    output req_ready, clr_ack, reg_q, owner, busy
  );

endinterface
`default_nettype wire

// File: rtl/reg_odd.sv
`default_nettype none
// ============================================================================
// reg_odd  : n-bit loadable register, synchronous clear wins over load
// Revision : 1.0
// ============================================================================
module reg_odd #(
  parameter int n = 8
) (
  input  wire logic         clk,
  input  wire logic         ld,
  input  wire logic         clr,
  input  wire logic [n-1:0] data_in,
  output logic      [n-1:0] data_out
);

  logic [n-1:0] data_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      data_q <= '0;
    end else if (ld) begin
      data_q <= data_in;
    end
  end

  assign data_out = data_q;

endmodule
`default_nettype wire

// File: rtl/reg_load_arbiter.sv
`default_nettype none
// ============================================================================
// reg_load_arbiter : round-robin grant/load/ack sequencer for one shared
//                    register, with a priority clear request
// Revision         : 1.0
// ============================================================================
module reg_load_arbiter
  import reg_arb_pkg::*;
#(
  parameter int n   = 8,
  parameter int REQ = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  reg_load_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(REQ);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [n-1:0]     data_q, data_d;

  logic             reg_ld;
  logic             reg_clr;
  logic [n-1:0]     reg_dout;
  logic [REQ-1:0]   ready;
  logic             clr_ack;
  logic             busy;

  // First valid requester at or after ptr, wrapping modulo REQ.
  function automatic logic [PTR_W-1:0] rr_pick(
    input logic [REQ-1:0]   valid,
    input logic [PTR_W-1:0] ptr
  );
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] pick;
    pick = ptr;
    for (int i = REQ - 1; i >= 0; i--) begin
      idx = ptr + PTR_W'(i);
      if (valid[idx]) begin
        pick = idx;
      end
    end
    return pick;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= INIT;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    reg_ld   = 1'b0;
    reg_clr  = 1'b0;
    ready    = '0;
    clr_ack  = 1'b0;
    busy     = 1'b1;

    case (state_q)
      INIT: begin
        reg_clr = 1'b1;
        state_d = IDLE;
      end
      IDLE: begin
        busy = 1'b0;
        if (bus.clr_req) begin
          state_d = CLEAR;
        end else if (|bus.req_valid) begin
          owner_d = rr_pick(bus.req_valid, rr_ptr_q);
          data_d  = bus.req_data[int'(owner_d) * n +: n];
          state_d = LOAD;
        end
      end
      LOAD: begin
        reg_ld  = 1'b1;
        state_d = ACK;
      end
      ACK: begin
        ready    = REQ'(1) << owner_q;
        rr_ptr_d = owner_q + PTR_W'(1);
        state_d  = IDLE;
      end
      CLEAR: begin
        reg_clr = 1'b1;
        clr_ack = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  reg_odd #(.n(n)) u_reg (
    .clk      (clk),
    .ld       (reg_ld),
    .clr      (reg_clr),
    .data_in  (data_q),
    .data_out (reg_dout)
  );

  assign bus.reg_q     = reg_dout;
  assign bus.owner     = owner_q;
  assign bus.req_ready = ready;
  assign bus.clr_ack   = clr_ack;
  assign bus.busy      = busy;

endmodule
`default_nettype wire

// File: tb/tb_reg_load_arbiter.sv
`default_nettype none
// ============================================================================
// tb_reg_load_arbiter : directed + random bench for reg_load_arbiter against a
//                       transaction-level model
// Revision            : 1.0
// ============================================================================
module tb_reg_load_arbiter;

  localparam int N = 8;
  localparam int R = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  reg_load_arbiter_if #(.n(N), .REQ(R)) bus ();

  reg_load_arbiter #(.n(N), .REQ(R)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: m_cnt counts cycles left in the current operation
  // (write: 2 = LOAD, 1 = ACK; clear: 1 = CLEAR), m_init marks the reset state.
  bit           m_init    = 1'b1;
  bit           m_known   = 1'b0;
  bit           m_started = 1'b0;
  bit           m_wr      = 1'b0;
  int           m_cnt     = 0;
  int           m_owner   = 0;
  int           m_ptr     = 0;
  int           m_w       = 0;
  logic [N-1:0] m_reg     = '0;
  logic [N-1:0] m_data    = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // rst_n only moves while clk is low, so clk tells the two triggers apart.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_init  = 1'b1;
      m_cnt   = 0;
      m_owner = 0;
      m_ptr   = 0;
      m_wr    = 1'b0;
      if (clk) begin
        m_reg     = '0;
        m_known   = 1'b1;
        m_started = 1'b1;
      end
    end else begin
      m_started = 1'b1;
      if (m_init) begin
        m_init  = 1'b0;
        m_reg   = '0;
        m_known = 1'b1;
      end else if (m_cnt == 0) begin
        if (bus.clr_req) begin
          m_wr  = 1'b0;
          m_cnt = 1;
        end else if (bus.req_valid != '0) begin
          m_w = -1;
          for (int k = 0; k < R; k++) begin
            if (m_w < 0 && bus.req_valid[(m_ptr + k) % R]) m_w = (m_ptr + k) % R;
          end
          m_owner = m_w;
          m_data  = bus.req_data[m_owner*N +: N];
          m_wr    = 1'b1;
          m_cnt   = 2;
        end
      end else begin
        if (m_wr && m_cnt == 2) begin
          m_reg   = m_data;
          m_known = 1'b1;
        end
        if (m_wr && m_cnt == 1) m_ptr = (m_owner + 1) % R;
        if (!m_wr) begin
          m_reg   = '0;
          m_known = 1'b1;
        end
        m_cnt--;
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("busy", 32'(bus.busy), 32'(m_init || m_cnt != 0));
      check("req_ready", 32'(bus.req_ready),
            (m_wr && m_cnt == 1) ? (32'd1 << m_owner) : 32'd0);
      check("clr_ack", 32'(bus.clr_ack), 32'(!m_wr && m_cnt == 1));
      check("owner", 32'(bus.owner), 32'(m_owner));
      if (m_known) check("reg_q", 32'(bus.reg_q), 32'(m_reg));
    end
  end

  // Advance to just after a falling edge; requesters drop on their ack.
  task automatic next_cycle();
    @(negedge clk);
    #1;
    for (int i = 0; i < R; i++) begin
      if (bus.req_ready[i]) bus.req_valid[i] = 1'b0;
    end
    if (bus.clr_ack) bus.clr_req = 1'b0;
  endtask

  initial begin
    int       got;
    bit       reraise;
    logic [3:0] exp_ready;
    logic [7:0] exp_reg;

    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.clr_req   = 1'b0;

    // Reset held for two edges
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_reg_q", 32'(bus.reg_q), 32'h00);
    check("rst_busy", 32'(bus.busy), 32'd1);
    #1 rst_n = 1'b1;
    next_cycle();
    check("rel_busy", 32'(bus.busy), 32'd0);
    check("rel_ready", 32'(bus.req_ready), 32'd0);

    // Fairness: all four pending, then requester 0 re-raised after its ack
    for (int i = 0; i < R; i++) begin
      bus.req_valid[i]       = 1'b1;
      bus.req_data[i*N +: N] = 8'(8'h11 * (i + 1));
    end
    got     = 0;
    reraise = 1'b0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      next_cycle();
      if (bus.req_ready != '0) begin
        exp_ready = (got < 4) ? (4'b0001 << got) : 4'b0001;
        exp_reg   = (got < 4) ? 8'(8'h11 * (got + 1)) : 8'h55;
        check("fair_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("fair_reg_q", 32'(bus.reg_q), 32'(exp_reg));
        if (got == 0) reraise = 1'b1;
        got++;
      end else if (reraise) begin
        bus.req_valid[0]   = 1'b1;
        bus.req_data[0 +: N] = 8'h55;
        reraise = 1'b0;
      end
    end
    if (got < 5) begin
      total++;
      bad++;
      $display("FAIL fair_timeout: actual=%0d pulses required=5", got);
    end
    next_cycle();

    // Single write from requester 2
    bus.req_valid[2]       = 1'b1;
    bus.req_data[2*N +: N] = 8'hA5;
    next_cycle();
    check("w_busy", 32'(bus.busy), 32'd1);
    check("w_owner", 32'(bus.owner), 32'd2);
    next_cycle();
    check("w_reg_q", 32'(bus.reg_q), 32'hA5);
    check("w_ready", 32'(bus.req_ready), 32'b0100);
    next_cycle();
    check("w_idle", 32'(bus.busy), 32'd0);

    // Clear beats a simultaneous write; pointer (3) still selects requester 1
    bus.clr_req            = 1'b1;
    bus.req_valid[1]       = 1'b1;
    bus.req_data[1*N +: N] = 8'h66;
    next_cycle();
    check("cp_ack", 32'(bus.clr_ack), 32'd1);
    next_cycle();
    check("cp_reg_q", 32'(bus.reg_q), 32'h00);
    check("cp_idle", 32'(bus.busy), 32'd0);
    next_cycle();
    check("cp_owner", 32'(bus.owner), 32'd1);
    next_cycle();
    check("cp_w_reg_q", 32'(bus.reg_q), 32'h66);
    check("cp_w_ready", 32'(bus.req_ready), 32'b0010);
    next_cycle();

    // Reset during LOAD drops the write
    bus.req_valid[0]     = 1'b1;
    bus.req_data[0 +: N] = 8'hC3;
    next_cycle();
    check("rm_load", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rm_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid[0] = 1'b0;
    next_cycle();
    check("rm_reg_q", 32'(bus.reg_q), 32'h00);
    check("rm_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b1;
    next_cycle();
    check("rm_idle", 32'(bus.busy), 32'd0);

    // Late clear and data change during LOAD are ignored until IDLE
    bus.req_valid[3]       = 1'b1;
    bus.req_data[3*N +: N] = 8'h77;
    next_cycle();
    bus.clr_req            = 1'b1;
    bus.req_data[3*N +: N] = 8'h99;
    next_cycle();
    check("li_reg_q", 32'(bus.reg_q), 32'h77);
    check("li_ready", 32'(bus.req_ready), 32'b1000);
    check("li_no_ack", 32'(bus.clr_ack), 32'd0);
    next_cycle();
    check("li_idle", 32'(bus.busy), 32'd0);
    next_cycle();
    check("li_ack", 32'(bus.clr_ack), 32'd1);
    next_cycle();
    check("li_reg_clr", 32'(bus.reg_q), 32'h00);

    // Random traffic, including protocol violations and resets
    for (int c = 0; c < 800; c++) begin
      next_cycle();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      for (int i = 0; i < R; i++) begin
        if (!bus.req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.req_valid[i]       = 1'b1;
            bus.req_data[i*N +: N] = 8'($urandom);
          end
        end else if ($urandom_range(0, 49) == 0) begin
          bus.req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          bus.req_data[i*N +: N] = 8'($urandom);
        end
      end
      if (!bus.clr_req && $urandom_range(0, 11) == 0) bus.clr_req = 1'b1;
    end

    rst_n = 1'b1;
    bus.req_valid = '0;
    bus.clr_req   = 1'b0;
    repeat (6) next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
